fetch_responder: RTL
====================

// Module: fetch_responder
// PURPOSE
// - Instruction-side responder serving the fetch stage: takes the PC driven each cycle and returns
//   the addressed instruction word one cycle later.
// - Sits between the PC register and the decode stage.
// - Honours the same stall (enable) and redirect (flush) controls as the fetch stage.
// - Preloadable through a write port for program loading.
// PARAMETERS
// - ADDR_WIDTH  8             PC / word-address width (word-addressed, PC+1 = next instruction)
// - DATA_WIDTH  32            instruction word width
// - DEPTH       2**ADDR_WIDTH number of instruction words stored; DEPTH <= 2**ADDR_WIDTH
// - NOP         '0            instruction word emitted on reset, flush or address fault
// - CNT_WIDTH   16            width of the FetchCount performance counter
// PORTS
// - clock        in   1           rising-edge clock
// - reset        in   1           synchronous, active-high reset
// - enable       in   1           1 = accept PC this cycle; 0 = stall, outputs hold
// - flush        in   1           redirect taken; squash the response being produced
// - PC           in   ADDR_WIDTH  fetch address
// - load_en      in   1           write load_data into memory at load_addr
// - load_addr    in   ADDR_WIDTH  load address
// - load_data    in   DATA_WIDTH  load word
// - Instruction  out  DATA_WIDTH  fetched instruction word (registered)
// - InstrPC      out  ADDR_WIDTH  PC that Instruction was fetched from (registered)
// - InstrValid   out  1           Instruction is a real fetch result, not a bubble
// - AddrFault    out  1           response came from PC >= DEPTH
// - FetchCount   out  CNT_WIDTH   number of valid responses delivered, saturating
// BEHAVIOUR
// - Reset (sync): Instruction=NOP, InstrPC=0, InstrValid=0, AddrFault=0, FetchCount=0.
//   Memory contents are NOT reset and survive reset. Reset overrides every other input.
// - Latency: 1 cycle. PC sampled at edge N with enable=1 gives Instruction/InstrPC/InstrValid
//   valid after edge N (visible cycle N+1).
// - Per-edge priority: reset > flush > enable > hold.
// - flush=1: Instruction<=NOP, InstrValid<=0, AddrFault<=0, InstrPC<=PC.
//   Applies regardless of enable; FetchCount unchanged.
// - enable=1, flush=0, PC<DEPTH: Instruction<=mem[PC], InstrPC<=PC, InstrValid<=1, AddrFault<=0.
// - enable=1, flush=0, PC>=DEPTH: Instruction<=NOP, InstrPC<=PC, InstrValid<=1, AddrFault<=1.
// - enable=0, flush=0: Instruction, InstrPC, InstrValid, AddrFault and FetchCount all hold.
// - FetchCount increments by 1 on every edge that writes InstrValid<=1 (including faults).
//   Saturates at 2**CNT_WIDTH-1; never wraps.
// - Load port: when load_en=1 and load_addr<DEPTH, mem[load_addr]<=load_data at the edge.
//   Acts independently of enable/flush. load_addr>=DEPTH is ignored.
//   Load is also ignored while reset=1.
// - Read/write collision: fetch of the address being loaded on the same edge returns the OLD word.
//   The new word is visible to fetches from the next edge on.
// - PC wrap: the responder does no arithmetic on PC; a PC wrapping 2**ADDR_WIDTH-1 -> 0 is fetched
//   as given.
// - Reset mid-stream: an in-flight response is discarded; InstrValid=0 on the first cycle after reset.
// TESTING
// - Load mem[0..3]=0x11,0x22,0x33,0x44; reset; enable=1, PC=0,1,2,3 ->
//   Instruction 0x11..0x44 one cycle later, InstrPC 0..3, InstrValid=1, FetchCount=4.
// - PC=2 with enable=1, then enable=0 for 3 cycles while PC=3 ->
//   Instruction stays 0x33, InstrPC=2, FetchCount unchanged.
// - enable=1, flush=1 with PC=1 ->
//   next cycle Instruction=NOP, InstrValid=0, FetchCount unchanged; flush with enable=0 gives the same result.
// - load_en=1, load_addr=5, load_data=0xAB same edge as fetch PC=5 (old 0x00) ->
//   Instruction=0x00; refetch PC=5 -> 0xAB.
// - DEPTH=4: fetch PC=6 -> Instruction=NOP, AddrFault=1, InstrValid=1;
//   load_addr=6 is ignored.
// - CNT_WIDTH=2: 5 consecutive valid fetches -> FetchCount=3 (saturated).
//   Assert reset mid-stream -> all outputs at reset values next cycle, memory intact on refetch.

Source files
------------

// File: rtl/fetch_responder_if.sv
// Fetch-side bus between the PC register, the instruction responder and decode.
// Carries the PC/control inputs, the program-load port and the registered response.
interface fetch_responder_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  enable;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] PC;
    logic                  load_en;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] Instruction;
    logic [ADDR_WIDTH-1:0] InstrPC;
    logic                  InstrValid;
    logic                  AddrFault;
    logic [CNT_WIDTH-1:0]  FetchCount;

    modport master (
        output enable, flush, PC, load_en, load_addr, load_data,
        input  Instruction, InstrPC, InstrValid, AddrFault, FetchCount
    );

    modport slave (
        input  enable, flush, PC, load_en, load_addr, load_data,
        output Instruction, InstrPC, InstrValid, AddrFault, FetchCount
    );
endinterface

// File: rtl/fetch_responder.sv
// Instruction responder: returns mem[PC] one cycle after the PC is accepted,
// with stall/flush control, a program-load port and a saturating fetch counter.
module fetch_responder #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 2**ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] NOP        = '0,
    parameter int                    CNT_WIDTH  = 16
) (
    input logic              clock,
    input logic              reset,
    fetch_responder_if.slave bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] instr_q;
    logic [ADDR_WIDTH-1:0] ipc_q;
    logic                  valid_q;
    logic                  fault_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  pc_ok;
    logic                  load_ok;
    logic [IW-1:0]         rd_idx;
    logic [IW-1:0]         wr_idx;

    assign pc_ok   = {1'b0, bus.PC} < LIMIT;
    assign load_ok = {1'b0, bus.load_addr} < LIMIT;
    assign rd_idx  = bus.PC[IW-1:0];
    assign wr_idx  = bus.load_addr[IW-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            instr_q <= NOP;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else if (bus.flush) begin
            instr_q <= NOP;
            ipc_q   <= bus.PC;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else if (bus.enable) begin
            instr_q <= pc_ok ? mem[rd_idx] : NOP;
            ipc_q   <= bus.PC;
            valid_q <= 1'b1;
            fault_q <= ~pc_ok;
            if (cnt_q != '1)
                cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    // Non-blocking write: a fetch of the same address this edge sees the old word.
    always_ff @(posedge clock) begin
        if (!reset && bus.load_en && load_ok)
            mem[wr_idx] <= bus.load_data;
    end

    assign bus.Instruction = instr_q;
    assign bus.InstrPC     = ipc_q;
    assign bus.InstrValid  = valid_q;
    assign bus.AddrFault   = fault_q;
    assign bus.FetchCount  = cnt_q;
endmodule
